// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared size codes, FSM states and lane constants for the load/store sequencer
package mac_defs;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_MERGE = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    localparam logic [31:0] LANE_BYTE_MASK = 32'h0000_00ff;
    localparam logic [31:0] LANE_HALF_MASK = 32'h0000_ffff;

    // An access is illegal when its size code is reserved or its offset breaks natural alignment.
    function automatic logic access_illegal(input size_e bhw, input logic [1:0] off);
        logic r;
        case (bhw)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = off[0];
            SZ_WORD: r = (off != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mac_lane_unit.sv
// rtl/mac_lane_unit.sv - combinational little-endian lane extract/extend and store merge
module mac_lane_unit
    import mac_defs::*;
(
    input  logic [31:0] i_word,
    input  size_e       i_bhw,
    input  logic [1:0]  i_offset,
    input  logic        i_sext,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [4:0]  w_byte_sh;
    logic [4:0]  w_half_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte_sh = {i_offset, 3'b000};
    assign w_half_sh = {i_offset[1], 4'b0000};
    assign w_byte    = i_word[w_byte_sh +: 8];
    assign w_half    = i_word[w_half_sh +: 16];

    // Select the addressed lane for loads and splice the store lane into the word for merges.
    always_comb begin
        o_load   = '0;
        o_merged = i_word;
        case (i_bhw)
            SZ_BYTE: begin
                o_load   = {{24{i_sext & w_byte[7]}}, w_byte};
                o_merged = (i_word & ~(LANE_BYTE_MASK << w_byte_sh))
                         | ((i_wdata & LANE_BYTE_MASK) << w_byte_sh);
            end
            SZ_HALF: begin
                o_load   = {{16{i_sext & w_half[15]}}, w_half};
                o_merged = (i_word & ~(LANE_HALF_MASK << w_half_sh))
                         | ((i_wdata & LANE_HALF_MASK) << w_half_sh);
            end
            SZ_WORD: begin
                o_load   = i_word;
                o_merged = i_wdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding load/store sequencer with read-modify-write sub-word stores
module mem_access_ctrl
    import mac_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_bhw,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_e            r_state;
    state_e            w_next;
    logic              w_accept;
    size_e             w_req_bhw;
    logic              w_req_illegal;
    logic              w_word_store;

    logic              r_we;
    logic              r_sext;
    size_e             r_bhw;
    logic [1:0]        r_off;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_word;
    logic [ADDR_W-3:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merged;

    assign w_req_bhw     = size_e'(req_bhw);
    assign w_req_illegal = access_illegal(w_req_bhw, req_addr[1:0]);
    assign w_word_store  = req_we && (w_req_bhw == SZ_WORD);

    mac_lane_unit u_lane (
        .i_word   (r_word),
        .i_bhw    (r_bhw),
        .i_offset (r_off),
        .i_sext   (r_sext),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    // State register; reset abandons any access in flight without a response.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_req_illegal)     w_next = ST_ERR;
                    else if (w_word_store) w_next = ST_WR;
                    else                   w_next = ST_RD;
                end
            end
            ST_RD: begin
                mem_req = 1'b1;
                if (mem_ack) w_next = r_we ? ST_MERGE : ST_DONE;
            end
            ST_MERGE: w_next = ST_WR;
            ST_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) w_next = ST_DONE;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                w_next     = ST_IDLE;
            end
            ST_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request fields latch on accept so memory-side outputs stay stable for the whole access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_sext      <= 1'b0;
            r_bhw       <= SZ_BYTE;
            r_off       <= '0;
            r_wdata     <= '0;
            r_word      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= req_we;
                r_sext     <= req_sext;
                r_bhw      <= w_req_bhw;
                r_off      <= req_addr[1:0];
                r_wdata    <= req_wdata;
                r_mem_addr <= req_addr[ADDR_W-1:2];
                if (w_word_store) r_mem_wdata <= req_wdata;
            end
            if ((r_state == ST_RD) && mem_ack) r_word <= mem_rdata;
            if (r_state == ST_MERGE)           r_mem_wdata <= w_merged;
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign resp_rdata = ((r_state == ST_DONE) && !r_we) ? w_load : '0;
    assign busy       = (r_state != ST_IDLE) | (req_valid & req_ready);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench with byte-level reference memory for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_bhw = 2'd0;
    logic        req_sext = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_bhw(req_bhw),
        .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          reqc;
        int          wr;
        int          cyc0;
        int          reqc0;
        int          wr0;
    } exp_t;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } preload_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          reqc_cnt = 0;
    int          wr_cnt = 0;
    int          mem_wait = 0;
    logic [31:0] tb_mem [256];
    logic [7:0]  ref_bytes [1024];
    exp_t        q [$];
    preload_t    pl_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_word(input int byte_addr, input logic [31:0] val);
        preload_t p;
        p.idx = byte_addr / 4;
        p.val = val;
        pl_q.push_back(p);
        for (int i = 0; i < 4; i++) ref_bytes[byte_addr + i] = val[8*i +: 8];
    endtask

    // Memory array updates: backdoor preloads and DUT writes, plus activity counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        while (pl_q.size() > 0) begin
            preload_t p;
            p = pl_q.pop_front();
            tb_mem[p.idx] <= p.val;
        end
        if (rst_n && mem_req) reqc_cnt <= reqc_cnt + 1;
        if (rst_n && mem_req && mem_ack && mem_we) begin
            tb_mem[mem_addr[7:0]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int          wcnt = 0;
    logic        prev_req = 1'b0;
    logic        prev_we = 1'b0;
    logic [29:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;

    // Memory responder: acks after mem_wait cycles, spurious acks while idle, stability of held request.
    always @(negedge clk) begin
        if (rst_n && mem_req && prev_req && !mem_ack) begin
            chk("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
            chk("mem_we_stable", 32'(mem_we), 32'(prev_we));
            chk("mem_wdata_stable", mem_wdata, prev_wdata);
        end
        prev_req   <= mem_req;
        prev_we    <= mem_we;
        prev_addr  <= mem_addr;
        prev_wdata <= mem_wdata;
        if (!rst_n || !mem_req) begin
            wcnt      <= 0;
            mem_ack   <= ($urandom_range(3) == 0);
            mem_rdata <= $urandom;
        end else if (wcnt >= mem_wait) begin
            mem_ack   <= 1'b1;
            mem_rdata <= tb_mem[mem_addr[7:0]];
        end else begin
            mem_ack   <= 1'b0;
            mem_rdata <= $urandom;
            wcnt      <= wcnt + 1;
        end
    end

    // Response monitor: pops the oldest expectation whenever the DUT presents a response.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && resp_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
                e = q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 32'(resp_err), 32'(e.err));
                chk("latency", 32'(cyc - e.cyc0), 32'(e.lat));
                chk("mem_req_cycles", 32'(reqc_cnt - e.reqc0), 32'(e.reqc));
                chk("mem_writes", 32'(wr_cnt - e.wr0), 32'(e.wr));
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic do_op(input logic we, input logic [1:0] bhw, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata, input int w);
        exp_t   e;
        int     nb;
        longint v;
        wait_ready();
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        chk("busy_idle", 32'(busy), 32'd0);
        nb      = (bhw == 2'd0) ? 1 : (bhw == 2'd1) ? 2 : 4;
        e.cyc0  = cyc;
        e.reqc0 = reqc_cnt;
        e.wr0   = wr_cnt;
        e.rdata = '0;
        e.err   = 1'b0;
        if (bhw == 2'd3 || (addr % nb) != 0) begin
            e.err = 1'b1; e.lat = 1; e.reqc = 0; e.wr = 0;
        end else if (!we) begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v + (longint'(ref_bytes[addr + i]) << (8 * i));
            if (sext && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
            e.rdata = v[31:0]; e.lat = 2 + w; e.reqc = 1 + w; e.wr = 0;
        end else begin
            for (int i = 0; i < nb; i++) ref_bytes[addr + i] = wdata[8*i +: 8];
            e.wr = 1;
            if (nb == 4) begin e.lat = 2 + w;     e.reqc = 1 + w;     end
            else         begin e.lat = 4 + 2 * w; e.reqc = 2 + 2 * w; end
        end
        q.push_back(e);
        mem_wait  = w;
        req_valid = 1'b1;
        req_we    = we;
        req_bhw   = bhw;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
        chk("busy_req", 32'(busy), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_bhw   = 2'($urandom);
        req_sext  = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic drain();
        int guard = 0;
        while ((q.size() != 0 || !req_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic reset_mid_write();
        int guard = 0;
        int wr_before;
        wait_ready();
        wr_before = wr_cnt;
        mem_wait  = 10;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_bhw   = 2'd2;
        req_sext  = 1'b0;
        req_addr  = 32'h108;
        req_wdata = 32'h55aa_55aa;
        @(negedge clk);
        req_valid = 1'b0;
        while (!(mem_req && mem_we) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_reached_wr", 32'(mem_req && mem_we), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("mid_rst");
        repeat (4) @(negedge clk);
        chk("rst_no_write", 32'(wr_cnt - wr_before), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic        sext;
        logic [1:0]  bhw;
        logic [1:0]  off;
        logic [31:0] addr;
        for (int i = 0; i < 256; i++) set_word(4 * i, $urandom);
        repeat (3) @(negedge clk);
        check_reset_state("init");
        rst_n = 1'b1;
        @(negedge clk);

        drain();
        set_word(32'h100, 32'h8081_f2f3);
        do_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0);
        do_op(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 0);
        do_op(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 1);
        do_op(1'b0, 2'd2, 1'b1, 32'h100, 32'h0, 2);
        drain();
        set_word(32'h100, 32'h1122_3344);
        do_op(1'b1, 2'd0, 1'b0, 32'h101, 32'hffff_ffab, 0);
        do_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
        do_op(1'b1, 2'd2, 1'b0, 32'h104, 32'hdead_beef, 3);
        do_op(1'b0, 2'd2, 1'b1, 32'h104, 32'h0, 0);
        do_op(1'b1, 2'd1, 1'b0, 32'h106, 32'h1234_8765, 2);
        do_op(1'b0, 2'd1, 1'b1, 32'h106, 32'h0, 0);
        do_op(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 3);
        do_op(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 3);
        do_op(1'b1, 2'd1, 1'b0, 32'h101, 32'hffff_ffff, 3);
        drain();

        reset_mid_write();
        do_op(1'b0, 2'd2, 1'b0, 32'h108, 32'h0, 1);
        drain();

        for (int k = 0; k < 250; k++) begin
            we   = 1'($urandom_range(1));
            sext = 1'($urandom_range(1));
            bhw  = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
            off  = 2'($urandom_range(3));
            if ($urandom_range(4) != 0) begin
                if (bhw == 2'd1) off[0] = 1'b0;
                if (bhw == 2'd2) off = 2'd0;
            end
            addr = {22'd0, 8'($urandom_range(255)), off};
            do_op(we, bhw, sext, addr, $urandom, int'($urandom_range(3)));
        end
        drain();

        for (int i = 0; i < 256; i++) begin
            chk("mem_final", tb_mem[i],
                {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store sequencer between the MEM pipeline stage and a single-port, word-wide data memory with a req/ack handshake. It accepts one access at a time and performs aligned byte/halfword/word loads with zero or sign extension. Sub-word stores are done as read-modify-write (read word, merge lane, write word). It stalls the pipeline while busy and flags misaligned or illegal accesses without touching memory.

Parameters:
ADDR_W, 32, byte-address width; memory is addressed with addr[ADDR_W-1:2]
DATA_W, 32, word width; fixed at 32, other values unsupported

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
req_valid  in  1  MEM stage presents an access
req_ready  out  1  controller can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_bhw  in  2  size: 0 byte, 1 half, 2 word, 3 illegal
req_sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  valid with resp_valid: misaligned or bhw==3
busy  out  1  pipeline stall = ~IDLE | (req_valid & req_ready)
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  memory write enable, qualified by mem_req
mem_addr  out  ADDR_W-2  word address
mem_wdata  out  32  full word to write
mem_rdata  in  32  read data, valid in mem_ack cycle
mem_ack  in  1  one-cycle completion pulse from memory

Behaviour:
- Reset (rst_n low at posedge): state=IDLE; req_ready=1 after reset; mem_req, mem_we, resp_valid, resp_err=0; resp_rdata, mem_addr, mem_wdata=0. Reset mid-access abandons it immediately, with no response.
- Accept: in IDLE with req_valid=1, latch all req_* fields. Next state:
  - ERR if bhw==3, or half with addr[0]=1, or word with addr[1:0]!=0.
  - RD if load, or if store with bhw 0/1.
  - WR if word store; mem_wdata=req_wdata.
- States: IDLE, RD, MERGE, WR, DONE, ERR.
- RD: mem_req=1, mem_we=0; wait for mem_ack. On ack, capture mem_rdata; go to DONE for a load, MERGE for a store.
- MERGE (1 cycle): replace the byte lane addr[1:0] (byte) or half lane addr[1] (half) of the captured word with req_wdata's low bits; other lanes unchanged; go to WR.
- WR: mem_req=1, mem_we=1; on mem_ack go to DONE.
- DONE: resp_valid=1, resp_err=0, then IDLE. ERR: resp_valid=1, resp_err=1, resp_rdata=0, then IDLE. ERR never asserts mem_req.
- Load extraction (little-endian): byte lane n = bits [8n+7:8n]; half lane 0 = [15:0], lane 1 = [31:16]. Sign-extend replicates the lane MSB into all upper bits; zero-extend fills with 0. Word loads ignore req_sext.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1. mem_ack in the same cycle mem_req first rises is legal. mem_ack while mem_req=0 is ignored.
- Latency from accept edge to resp_valid, with 1-cycle memory (ack in first request cycle):
  - word store: 2 cycles
  - load: 2 cycles
  - sub-word store: 4 cycles
  - error: 1 cycle
  - each memory wait cycle adds 1.
- No new request is accepted in the DONE/ERR cycle; back-to-back throughput is one access per latency+1 cycles.

Decomposition:
- Shared package/include mac_defs: size codes (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2), FSM state encodings, lane-select constants.
- One natural sub-module, mac_lane_unit: purely combinational. Provides load extraction/extension and store merge from (word, bhw, offset, sext, wdata). It is reused by the pipeline's forwarding checks.

Test Plan:
- Memory word 0x8081_F2F3 at 0x100; lb sext, addr 0x103 -> resp_rdata=0xFFFF_FF80, resp_err=0, 1 read, no write.
- Same word; lhu, addr 0x102 -> 0x0000_8081. lh, addr 0x100 -> 0xFFFF_F2F3.
- sb 0xAB at 0x101, memory 0x1122_3344 -> read then write 0x1122_AB44; resp at 4 cycles with zero-wait memory.
- sw 0xDEAD_BEEF at 0x104, mem_ack delayed 3 cycles -> mem_req/addr/wdata held stable; exactly 1 write; resp 5 cycles after accept.
- lw at 0x102 and bhw=3 -> resp_err=1 after 1 cycle, resp_rdata=0, mem_req never asserted.
- rst_n low during WR wait -> next cycle IDLE, mem_req=0, no resp_valid; a following load completes normally.
